barrett_rr_sched_829: RTL and testbench

//  Shares one pipelined Barrett reduction datapath (q=829, mu=1264, k=10) among
//  NUM_REQ requesters. Round-robin arbitration, valid/ready handshake on both

---
 rtl/barrett_rr_sched_829.sv | 122 ++++++++++++
 tb/tb_barrett_rr_sched_829.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/barrett_rr_sched_829.sv
// Round-robin shared Barrett reducer (q=829, mu=1264, k=10): NUM_REQ requesters
// feed a 3-stage pipeline whose results come back tagged with the requester index.
module barrett_rr_sched_829 #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*19-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [9:0]              rsp_data,
  output logic [1:0]              occupancy
);

  localparam int unsigned N = NUM_REQ;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant_idx;
  logic            found;
  logic            stall;
  logic            accept;
  logic [18:0]     sel_data;

  logic            s1_valid;
  logic [18:0]     s1_x;
  logic [20:0]     s1_qh;
  logic [ID_W-1:0] s1_id;

  logic            s2_valid;
  logic [11:0]     s2_r;
  logic [ID_W-1:0] s2_id;

  logic [20:0]     s1_qh_d;
  logic [10:0]     s2_t;
  logic [20:0]     s2_tq;
  logic [20:0]     s2_r_full;
  logic [11:0]     s3_r1;
  logic [11:0]     s3_r2;
  logic [1:0]      occ_d;

  assign stall  = rsp_valid & ~rsp_ready;
  assign accept = |req_ready;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req_valid[(32'(ptr) + i) % N]) begin
        found     = 1'b1;
        grant_idx = ID_W'((32'(ptr) + i) % N);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found && !stall) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx == ID_W'(i)) sel_data = req_data[19*i +: 19];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Barrett datapath; estimate undershoots by at most 2q, so r < 3*829 fits 12 bits.
  always_comb begin
    s1_qh_d   = 21'(sel_data[18:10]) * 21'd1264;
    s2_t      = s1_qh[20:10];
    s2_tq     = 21'(s2_t) * 21'd829;
    s2_r_full = 21'(s1_x) - s2_tq;
    s3_r1     = (s2_r >= 12'd829) ? s2_r - 12'd829 : s2_r;
    s3_r2     = (s3_r1 >= 12'd829) ? s3_r1 - 12'd829 : s3_r1;
  end

  always_comb begin
    occ_d = 2'(accept) + 2'(s1_valid) + 2'(s2_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_qh     <= '0;
      s1_id     <= '0;
      s2_valid  <= 1'b0;
      s2_r      <= '0;
      s2_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      occupancy <= '0;
    end else if (!stall) begin
      s1_valid  <= accept;
      s1_x      <= sel_data;
      s1_qh     <= s1_qh_d;
      s1_id     <= grant_idx;
      s2_valid  <= s1_valid;
      s2_r      <= s2_r_full[11:0];
      s2_id     <= s1_id;
      rsp_valid <= s2_valid;
      rsp_id    <= s2_id;
      rsp_data  <= s3_r2[9:0];
      occupancy <= occ_d;
    end
  end

endmodule

// File: tb/tb_barrett_rr_sched_829.sv
// Self-checking bench: directed corner cases plus randomized traffic checked
// against a queue-based reference of arbitration order and din mod 829.
module tb_barrett_rr_sched_829;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*19-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [9:0]      rsp_data;
  logic [1:0]      occupancy;

  barrett_rr_sched_829 #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  int   ptr_m;
  int   q_id[$];
  int   q_dat[$];
  logic [N-1:0] refill;
  bit   rand_mode;
  int   cyc, grant_cyc, rsp_first, last_g, accepted;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_grant(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [18:0] rnd_din();
    case ($urandom % 8)
      0: return 19'd0;
      1: return 19'd524287;
      2: return 19'(829 * $urandom_range(1, 632) - 1);
      3: return 19'(829 * $urandom_range(0, 632));
      default: return 19'($urandom % 524288);
    endcase
  endfunction

  // One clock: check at negedge, update the model, then drive new inputs after the edge.
  task automatic step();
    int g;
    bit stalled;
    @(negedge clk);
    cyc++;
    stalled = rsp_valid && !rsp_ready;
    g = stalled ? -1 : exp_grant(req_valid, ptr_m);
    check("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
    check("occupancy", occupancy, q_id.size());
    if (rsp_valid) begin
      if (rsp_first < 0) rsp_first = cyc;
      if (q_id.size() == 0) begin
        check("rsp_spurious", 1, 0);
      end else begin
        check("rsp_id", rsp_id, q_id[0]);
        check("rsp_data", rsp_data, q_dat[0]);
        if (rsp_ready) begin
          void'(q_id.pop_front());
          void'(q_dat.pop_front());
        end
      end
    end
    if (g >= 0) begin
      q_id.push_back(g);
      q_dat.push_back(int'(req_data[19*g +: 19]) % 829);
      ptr_m     = (g + 1) % N;
      grant_cyc = cyc;
      accepted++;
    end
    last_g = g;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rand_mode) begin
        if (g == i) begin
          req_valid[i] = 1'($urandom % 2);
          req_data[19*i +: 19] = rnd_din();
        end else if (!req_valid[i] && ($urandom % 3 == 0)) begin
          req_valid[i] = 1'b1;
          req_data[19*i +: 19] = rnd_din();
        end
      end else if (g == i) begin
        if (refill[i]) req_data[19*i +: 19] = rnd_din();
        else req_valid[i] = 1'b0;
      end
    end
    if (rand_mode) rsp_ready = ($urandom % 4) != 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    q_id.delete();
    q_dat.delete();
    ptr_m = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic single(input int id, input logic [18:0] din);
    req_valid = '0;
    refill    = '0;
    rsp_ready = 1'b1;
    req_data[19*id +: 19] = din;
    req_valid[id] = 1'b1;
    rsp_first = -1;
    repeat (6) step();
    check("latency", rsp_first - grant_cyc, 3);
    check("single_drained", q_id.size(), 0);
  endtask

  initial begin
    rst_n = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    refill = '0; rand_mode = 1'b0; cyc = 0; grant_cyc = 0; rsp_first = -1;
    last_g = -1; accepted = 0; ptr_m = 0;
    #2;
    do_reset();
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_occ", occupancy, 0);

    // Boundary operands
    single(0, 19'd829);
    single(0, 19'd828);
    single(0, 19'd1657);
    single(3, 19'd524287);
    single(3, 19'd0);
    single(2, 19'd1658);

    // All requesters continuously valid from ptr=0
    do_reset();
    refill = '1;
    for (int i = 0; i < N; i++) req_data[19*i +: 19] = rnd_din();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("rr_order", last_g, k % N);
    end

    // Full pipe stalled for 5 cycles
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_occ", occupancy, 3);
      check("stall_valid", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (6) step();
    check("stall_drained", q_id.size(), 0);

    // Reset with two ops in flight
    refill = '0;
    req_data[0 +: 19]  = 19'd1234;
    req_data[19 +: 19] = 19'd4321;
    req_valid = 4'b0011;
    step();
    step();
    check("pre_reset_occ", occupancy, 2);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", rsp_valid, 0);
    check("async_rst_occ", occupancy, 0);
    req_valid = '0;
    q_id.delete();
    q_dat.delete();
    ptr_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) req_data[19*i +: 19] = rnd_din();
    req_valid = '1;
    step();
    check("post_reset_grant", last_g, 0);
    req_valid = '0;
    repeat (6) step();

    // Randomized traffic
    accepted  = 0;
    rand_mode = 1'b1;
    for (int c = 0; c < 60000 && accepted < 10000; c++) step();
    check("rand_ops_done", accepted >= 10000, 1);
    rand_mode = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && q_id.size() != 0; c++) step();
    check("final_drain", q_id.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
